uart_tx_fifo: RTL and testbench

Transmit buffer that sits between the UART CSR block and the UART transmitter. Software writes bytes into the FIFO through the CSR data/start strobe. The FIFO presents them in order to the transmitter over a valid/ready handshake, so back-to-back bytes go out without CPU polling per byte. It also provides level, watermark, overflow and drain status for the status register.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_fifo_mem.sv | 33 +++
 rtl/uart_tx_fifo.sv | 120 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants used by the CSR block, the TX FIFO and the transmitter.
// No logic, so no latency.
// No handshakes, so no backpressure.
package uart_pkg;

    // Width of one UART character as carried between CSR, FIFO and transmitter.
    localparam int UART_DATA_W = 8;

    // Default transmit buffer geometry.
    localparam int UART_TX_FIFO_DEPTH  = 16;
    localparam int UART_TX_FIFO_LOW_WM = 4;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
// Latency: a write lands at the clock edge; the read data follows i_rd_addr combinationally.
// Backpressure: none. The caller only asserts i_wr_en for accepted writes.
//
// Ports:
//   i_clk                      write clock
//   i_wr_en, i_wr_addr, i_wr_data   write port
//   i_rd_addr, o_rd_data            asynchronous read port
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    // Contents are not reset; the FIFO's valid flag says whether the head means anything.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule : uart_fifo_mem

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: CSR byte writes in, first-word fall-through valid/ready out, plus status.
// Latency: a byte written at edge N is presented on o_tx_valid/o_tx_data right after edge N.
// Backpressure: the head is held until i_tx_ready; writes while full are dropped and set o_ovf.
//
// Ports:
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_wr_en, i_wr_data, o_full           CSR write side
//   i_flush, i_ovf_clr                   synchronous clear of contents, clear of sticky overflow
//   o_tx_valid, o_tx_data, i_tx_ready    transmitter handshake
//   o_level, o_empty, o_ovf, o_low_wm, o_drained   status register bits
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int DEPTH  = UART_TX_FIFO_DEPTH,
    parameter  int LOW_WM = UART_TX_FIFO_LOW_WM,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_full,
    input  logic              i_flush,
    input  logic              i_ovf_clr,
    output logic              o_tx_valid,
    output logic [DATA_W-1:0] o_tx_data,
    input  logic              i_tx_ready,
    output logic [AW:0]       o_level,
    output logic              o_empty,
    output logic              o_ovf,
    output logic              o_low_wm,
    output logic              o_drained
);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          ovf_q;
    logic          drained_q;

    logic          wr_acc;
    logic          rd_acc;
    logic          wr_over;

    // Flags come straight from the registered level so they never glitch with inputs.
    assign o_empty    = (level_q == '0);
    assign o_full     = (level_q == (AW+1)'(DEPTH));
    assign o_low_wm   = (level_q <= (AW+1)'(LOW_WM));
    assign o_tx_valid = !o_empty;
    assign o_level    = level_q;
    assign o_ovf      = ovf_q;
    assign o_drained  = drained_q;

    // Fullness is judged on the registered level, so a same-cycle read never
    // makes room for a write. Flush discards both sides of the cycle.
    assign wr_acc  = i_wr_en && !o_full && !i_flush;
    assign rd_acc  = o_tx_valid && i_tx_ready && !i_flush;
    assign wr_over = i_wr_en && o_full;

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (wr_acc),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data (i_wr_data),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (o_tx_data)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (wr_acc && !rd_acc) begin
                level_q <= level_q + (AW+1)'(1);
            end else if (rd_acc && !wr_acc) begin
                level_q <= level_q - (AW+1)'(1);
            end
        end
    end

    // Sticky overflow: a fresh overflow beats a same-cycle clear. Flush leaves it alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
        end else if (wr_over) begin
            ovf_q <= 1'b1;
        end else if (i_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    // Pulse only when the last byte leaves through the transmitter. A write that
    // refills the slot in the same cycle keeps the level at 1, so no pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drained_q <= 1'b0;
        end else begin
            drained_q <= rd_acc && !wr_acc && (level_q == (AW+1)'(1));
        end
    end

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LWM   = 4;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_wr_en;
    logic [DW-1:0] i_wr_data;
    logic          o_full;
    logic          i_flush;
    logic          i_ovf_clr;
    logic          o_tx_valid;
    logic [DW-1:0] o_tx_data;
    logic          i_tx_ready;
    logic [4:0]    o_level;
    logic          o_empty;
    logic          o_ovf;
    logic          o_low_wm;
    logic          o_drained;

    uart_tx_fifo dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .o_full     (o_full),
        .i_flush    (i_flush),
        .i_ovf_clr  (i_ovf_clr),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .i_tx_ready (i_tx_ready),
        .o_level    (o_level),
        .o_empty    (o_empty),
        .o_ovf      (o_ovf),
        .o_low_wm   (o_low_wm),
        .o_drained  (o_drained)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard: bytes the FIFO must still deliver, oldest first.
    logic [DW-1:0] exp_q[$];

    // Reference model state.
    int   m_level = 0;
    logic m_ovf   = 1'b0;
    logic m_drain = 1'b0;
    int   drain_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, " level"},   32'(o_level),   32'(m_level));
        chk({tag, " empty"},   32'(o_empty),   32'(m_level == 0));
        chk({tag, " full"},    32'(o_full),    32'(m_level == DEPTH));
        chk({tag, " valid"},   32'(o_tx_valid), 32'(m_level != 0));
        chk({tag, " low_wm"},  32'(o_low_wm),  32'(m_level <= LWM));
        chk({tag, " ovf"},     32'(o_ovf),     32'(m_ovf));
        chk({tag, " drained"}, 32'(o_drained), 32'(m_drain));
    endtask

    // Monitor: every cycle the transmitter takes the head, it must match the scoreboard.
    always @(negedge i_clk) begin
        if (i_rst_n && !i_flush && o_tx_valid && i_tx_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexpected: got %0h expected nothing", o_tx_data);
            end else begin
                chk("tx_data", 32'(o_tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock cycle: drive inputs at posedge+1, update the model, check status at next posedge+1.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic rdy,
                        input logic fl, input logic oc);
        logic m_wr;
        logic m_rd;
        i_wr_en    = we;
        i_wr_data  = wd;
        i_tx_ready = rdy;
        i_flush    = fl;
        i_ovf_clr  = oc;
        m_wr = we && (m_level < DEPTH) && !fl;
        m_rd = rdy && (m_level > 0) && !fl;
        if (we && m_level == DEPTH) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        m_drain = m_rd && !m_wr && (m_level == 1);
        if (fl) begin
            exp_q.delete();
            m_level = 0;
        end else begin
            if (m_wr) exp_q.push_back(wd);
            if (m_wr && !m_rd) m_level++;
            if (m_rd && !m_wr) m_level--;
        end
        @(posedge i_clk);
        #1;
        if (o_drained) drain_pulses++;
        chk_status("step");
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_wr_en    = 1'b0;
        i_wr_data  = '0;
        i_flush    = 1'b0;
        i_ovf_clr  = 1'b0;
        i_tx_ready = 1'b0;

        // Reset values.
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk_status("reset");

        // Fill 0x00..0x0F with transmitter stalled, then overflow, then clear.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("fill full", 32'(o_full), 32'd1);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        chk("ovf set", 32'(o_ovf), 32'd1);
        chk("ovf level", 32'(o_level), 32'd16);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf cleared", 32'(o_ovf), 32'd0);

        // Drain in order, one per cycle; expect exactly one drained pulse.
        drain_pulses = 0;
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        chk("drain pulses", 32'(drain_pulses), 32'd1);
        chk("drain sb empty", 32'(exp_q.size()), 32'd0);

        // Simultaneous write and read at level 3.
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("simul level", 32'(o_level), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("simul sb empty", 32'(exp_q.size()), 32'd0);

        // Write at full with a same-cycle read: no pass-through, overflow set.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        chk("full rd+wr level", 32'(o_level), 32'd15);
        // Flush while overflow is set: contents gone, overflow kept.
        step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        chk("flush ovf kept", 32'(o_ovf), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Wrap-around: 40 bytes with random handshakes, never overflowing.
        begin
            int sent = 0;
            for (int c = 0; c < 2000 && (sent < 40 || m_level > 0); c++) begin
                logic we;
                logic rdy;
                we  = (sent < 40) && (m_level < DEPTH) && ($urandom_range(0, 2) != 0);
                rdy = ($urandom_range(0, 1) != 0);
                step(we, 8'(8'h30 + sent), rdy, 1'b0, 1'b0);
                if (we) sent++;
            end
            chk("wrap sent", 32'(sent), 32'd40);
            chk("wrap sb empty", 32'(exp_q.size()), 32'd0);
        end

        // Flush at level 5 with a same-cycle write of 0x77.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        chk("pre-flush level", 32'(o_level), 32'd5);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        chk("flush level", 32'(o_level), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("flush no drain", 32'(o_drained), 32'd0);

        // Async reset mid-stream: valid must drop before any clock edge.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("async valid", 32'(o_tx_valid), 32'd0);
        chk("async level", 32'(o_level), 32'd0);
        exp_q.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        m_drain = 1'b0;
        i_wr_en = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk_status("post-reset");
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("final sb empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_tx_fifo
